// File: rtl/ula_8_bits.sv
// 8-bit ALU: two cascaded 74181-style 4-bit slices, 16 logic + 16 arithmetic functions.
// Latency: 1 cycle (combinational datapath, registered outputs).
// Backpressure: none; accepts a new operation every cycle, no handshake.
//
// Ports (top, ula_8_bits):
//   clk     in   1  system clock
//   rst     in   1  synchronous reset, active-high, priority over operation
//   a, b    in   8  operands
//   s       in   4  function select
//   m       in   1  mode: 1 = logic, 0 = arithmetic
//   c_in    in   1  carry in (adds 1 to arithmetic result)
//   f       out  8  registered result
//   a_eq_b  out  1  registered a == b flag
//   c_out   out  1  registered carry out of bit 7 (0 in logic mode)

// One 4-bit slice. Builds the 74181-style per-bit terms X/Y from the select
// lines, then either combines them bitwise (logic mode) or adds them with a
// full carry-lookahead across the four bits (arithmetic mode).
module ula_8_bits_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out
);

  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    // Select lines act as bitwise enables on the four minterms of (a, b).
    x = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});

    // Generate / propagate for x + y. Using xor as propagate lets the
    // same term serve as the half-sum in both modes.
    g = x & y;
    p = x ^ y;

    // Flat lookahead: every carry is a two-level function of g, p and c_in.
    c[0] = c_in;
    c[1] = g[0]
         | (p[0] & c[0]);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c[0]);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);

    // Logic mode is the carry-free complement of the half-sum; carries are
    // suppressed so c_in has no effect and the slice reports no carry.
    if (m) begin
      f     = ~p;
      c_out = 1'b0;
    end else begin
      f     = p ^ c[3:0];
      c_out = c[4];
    end
  end

endmodule

module ula_8_bits (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       a_eq_b,
  output logic       c_out
);

  logic [3:0] lo_f;
  logic [3:0] hi_f;
  logic       lo_c;
  logic       hi_c;
  logic [7:0] f_nxt;
  logic       eq_nxt;

  ula_8_bits_slice u_lo (
    .a     (a[3:0]),
    .b     (b[3:0]),
    .s     (s),
    .m     (m),
    .c_in  (c_in),
    .f     (lo_f),
    .c_out (lo_c)
  );

  // Low-slice carry ripples into the high slice; lookahead stays within a slice.
  ula_8_bits_slice u_hi (
    .a     (a[7:4]),
    .b     (b[7:4]),
    .s     (s),
    .m     (m),
    .c_in  (lo_c),
    .f     (hi_f),
    .c_out (hi_c)
  );

  always_comb begin
    f_nxt  = {hi_f, lo_f};
    // Straight operand compare, independent of the selected function.
    eq_nxt = (a == b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f      <= 8'h00;
      a_eq_b <= 1'b0;
      c_out  <= 1'b0;
    end else begin
      f      <= f_nxt;
      a_eq_b <= eq_nxt;
      c_out  <= hi_c;
    end
  end

endmodule

// File: tb/tb_ula_8_bits.sv
// Testbench for ula_8_bits: scoreboard queue fed by the driver, drained by a monitor.
// Latency: expects each operation's result one rising edge after it is driven.
// Backpressure: none; one operation issued per cycle.
module tb_ula_8_bits;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] s;
  logic       m;
  logic       c_in;
  logic [7:0] f;
  logic       a_eq_b;
  logic       c_out;

  int checks   = 0;
  int failures = 0;

  // Expected {a_eq_b, c_out, f} per issued operation, plus a label for reporting.
  logic [9:0] exp_q[$];
  string      name_q[$];

  ula_8_bits dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .s      (s),
    .m      (m),
    .c_in   (c_in),
    .f      (f),
    .a_eq_b (a_eq_b),
    .c_out  (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the function tables: returns {c_out, f}.
  function automatic logic [8:0] ref_alu(input logic [7:0] ra, input logic [7:0] rb,
                                         input logic [3:0] rs, input logic rm,
                                         input logic rc);
    logic [7:0] lf;
    logic [7:0] op1;
    logic [7:0] op2;
    int         sum;
    if (rm) begin
      case (rs)
        4'h0: lf = ~ra;
        4'h1: lf = ~(ra | rb);
        4'h2: lf = ~ra & rb;
        4'h3: lf = 8'h00;
        4'h4: lf = ~(ra & rb);
        4'h5: lf = ~rb;
        4'h6: lf = ra ^ rb;
        4'h7: lf = ra & ~rb;
        4'h8: lf = ~ra | rb;
        4'h9: lf = ~(ra ^ rb);
        4'hA: lf = rb;
        4'hB: lf = ra & rb;
        4'hC: lf = 8'hFF;
        4'hD: lf = ra | ~rb;
        4'hE: lf = ra | rb;
        default: lf = ra;
      endcase
      return {1'b0, lf};
    end
    case (rs)
      4'h0: begin op1 = ra;        op2 = 8'h00;     end
      4'h1: begin op1 = ra | rb;   op2 = 8'h00;     end
      4'h2: begin op1 = ra | ~rb;  op2 = 8'h00;     end
      4'h3: begin op1 = 8'h00;     op2 = 8'hFF;     end
      4'h4: begin op1 = ra;        op2 = ra & ~rb;  end
      4'h5: begin op1 = ra | rb;   op2 = ra & ~rb;  end
      4'h6: begin op1 = ra;        op2 = ~rb;       end
      4'h7: begin op1 = ra & ~rb;  op2 = 8'hFF;     end
      4'h8: begin op1 = ra;        op2 = ra & rb;   end
      4'h9: begin op1 = ra;        op2 = rb;        end
      4'hA: begin op1 = ra | ~rb;  op2 = ra & rb;   end
      4'hB: begin op1 = ra & rb;   op2 = 8'hFF;     end
      4'hC: begin op1 = ra;        op2 = ra;        end
      4'hD: begin op1 = ra | rb;   op2 = ra;        end
      4'hE: begin op1 = ra | ~rb;  op2 = ra;        end
      default: begin op1 = ra;     op2 = 8'hFF;     end
    endcase
    sum = int'(op1) + int'(op2) + int'(rc);
    return {(sum > 255), sum[7:0]};
  endfunction

  // Drive one operation (inputs settle away from the rising edge) and queue
  // its expected result for the monitor.
  task automatic issue(input string nm, input logic rrst, input logic [7:0] ra,
                       input logic [7:0] rb, input logic [3:0] rs,
                       input logic rm, input logic rc);
    logic [8:0] r;
    rst  = rrst;
    a    = ra;
    b    = rb;
    s    = rs;
    m    = rm;
    c_in = rc;
    if (rrst) begin
      exp_q.push_back(10'h000);
    end else begin
      r = ref_alu(ra, rb, rs, rm, rc);
      exp_q.push_back({(ra == rb), r});
    end
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // Monitor: every rising edge produces one registered result for the
  // oldest outstanding operation.
  initial begin
    logic [9:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({a_eq_b, c_out, f} !== e) begin
          failures++;
          $display("FAIL %s: got f=%h c_out=%b a_eq_b=%b, want f=%h c_out=%b a_eq_b=%b",
                   nm, f, c_out, a_eq_b, e[7:0], e[8], e[9]);
        end
      end
    end
  end

  initial begin
    int budget;
    // Reset with arbitrary inputs, then a couple more reset cycles.
    issue("reset",     1'b1, 8'h5A, 8'h5A, 4'h9, 1'b0, 1'b1);
    issue("reset2",    1'b1, 8'hFF, 8'h01, 4'h9, 1'b0, 1'b0);
    // Carry across the slice boundary and wrap-around.
    issue("add_0f_01", 1'b0, 8'h0F, 8'h01, 4'h9, 1'b0, 1'b0);
    issue("add_ff_01", 1'b0, 8'hFF, 8'h01, 4'h9, 1'b0, 1'b0);
    issue("sub_aa_aa", 1'b0, 8'hAA, 8'hAA, 4'h6, 1'b0, 1'b1);
    issue("dec_00",    1'b0, 8'h00, 8'h3C, 4'hF, 1'b0, 1'b0);
    issue("dbl_ff_c1", 1'b0, 8'hFF, 8'h12, 4'hC, 1'b0, 1'b1);
    // Logic functions, c_in must be ignored.
    issue("xor_aa_55", 1'b0, 8'hAA, 8'h55, 4'h6, 1'b1, 1'b1);
    issue("and_aa_55", 1'b0, 8'hAA, 8'h55, 4'hB, 1'b1, 1'b0);
    issue("nota_aa",   1'b0, 8'hAA, 8'h55, 4'h0, 1'b1, 1'b1);
    // Equality flag toggling on consecutive cycles.
    issue("eq_aa_aa",  1'b0, 8'hAA, 8'hAA, 4'h0, 1'b1, 1'b0);
    issue("ne_aa_ab",  1'b0, 8'hAA, 8'hAB, 4'h0, 1'b1, 1'b0);
    // Reset in the middle of traffic must override the operation.
    issue("reset_mid", 1'b1, 8'hFF, 8'h01, 4'h9, 1'b0, 1'b1);
    // Sweep every (m, s) combination with random operands and carry.
    for (int mm = 0; mm < 2; mm++) begin
      for (int ss = 0; ss < 16; ss++) begin
        issue($sformatf("sweep_m%0d_s%h", mm, ss), 1'b0, 8'($urandom), 8'($urandom),
              4'(ss), 1'(mm), 1'($urandom_range(0, 1)));
      end
    end
    // Random traffic, with a bias toward equal operands and occasional reset.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      issue($sformatf("rand_%0d", i), ($urandom_range(0, 31) == 0), ra, rb,
            4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    // Park in reset while the last results drain.
    rst = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
